// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the single-port memory.
// Latency: none, wires only.
// Backpressure: requesters hold req and payload until their ready pulse (fetch may also withdraw on flush).
interface mem_port_arbiter_if;
   // instruction-fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_ready;
   logic [31:0] if_rdata;
   // data port
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        dm_err;
   // single-port memory
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // arbiter side
   modport slave (
      input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ready, if_rdata, dm_ready, dm_rdata, dm_err, mem_en, mem_we, mem_addr, mem_wdata
   );

   // requester/memory side
   modport master (
      output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ready, if_rdata, dm_ready, dm_rdata, dm_err, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, data first with fetch starvation guard.
// Latency: store ready 2 cycles after grant, load/fetch 2+MEM_LAT, misaligned data 1 cycle (error, no memory access).
// Backpressure: one access in flight; requests seen outside IDLE simply wait, the grant is only made in IDLE.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT       = 1,
   parameter int unsigned MAX_DM_STREAK = 3
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int unsigned      SW         = $clog2(MAX_DM_STREAK + 2);
   localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DM_STREAK);
   localparam logic [2:0]       LAT_INIT   = 3'(MEM_LAT - 1);

   state_t        state_q,    state_d;
   logic [SW-1:0] streak_q,   streak_d;
   logic          gnt_if_q,   gnt_if_d;    // 1 = fetch owns the current access
   logic          we_q,       we_d;
   logic [31:0]   addr_q,     addr_d;
   logic [31:0]   wdata_q,    wdata_d;
   logic          err_q,      err_d;       // misaligned data access
   logic          flushed_q,  flushed_d;   // in-flight fetch was cancelled
   logic [2:0]    lat_q,      lat_d;       // WAIT cycles still to go after this one
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;

   logic          fetch_ok;
   logic          fetch_win;
   logic          in_done;

   // State and datapath registers; synchronous reset clears everything and aborts any access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         streak_q   <= '0;
         gnt_if_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         flushed_q  <= 1'b0;
         lat_q      <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         gnt_if_q   <= gnt_if_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         flushed_q  <= flushed_d;
         lat_q      <= lat_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Arbitration, next-state and output decode.
   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      gnt_if_d   = gnt_if_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      flushed_d  = flushed_q;
      lat_d      = lat_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;

      // A flush in the arbitration cycle withdraws the fetch; data may still be granted.
      fetch_ok  = bus.if_req && !bus.if_flush;
      fetch_win = fetch_ok && (!bus.dm_req || (streak_q == STREAK_MAX));

      case (state_q)
         IDLE: begin
            flushed_d = 1'b0;
            // Streak saturates so a flush-blocked fetch at the limit still wins next time.
            if (!bus.if_req || fetch_win) begin
               streak_d = '0;
            end else if (bus.dm_req && (streak_q != STREAK_MAX)) begin
               streak_d = streak_q + 1'b1;
            end
            if (fetch_win) begin
               gnt_if_d = 1'b1;
               we_d     = 1'b0;
               addr_d   = bus.if_addr & ~32'h3;
               wdata_d  = '0;
               err_d    = 1'b0;
               state_d  = ISSUE;
            end else if (bus.dm_req) begin
               gnt_if_d = 1'b0;
               we_d     = bus.dm_we;
               addr_d   = bus.dm_addr & ~32'h3;
               wdata_d  = bus.dm_wdata;
               err_d    = (bus.dm_addr[1:0] != 2'b00);
               state_d  = (bus.dm_addr[1:0] != 2'b00) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (gnt_if_q && bus.if_flush) flushed_d = 1'b1;
            if (we_q) begin
               state_d = DONE;
            end else begin
               lat_d   = LAT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (gnt_if_q && bus.if_flush) flushed_d = 1'b1;
            if (lat_q == '0) begin
               // A cancelled fetch does not disturb the last delivered instruction.
               if (!gnt_if_q) begin
                  dm_rdata_d = bus.mem_rdata;
               end else if (!flushed_q && !bus.if_flush) begin
                  if_rdata_d = bus.mem_rdata;
               end
               state_d = DONE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are forced low for the whole reset cycle, not just after the edge.
      in_done       = (state_q == DONE) && !reset;
      busy          = (state_q != IDLE) && !reset;
      bus.mem_en    = (state_q == ISSUE) && !reset;
      bus.mem_we    = (state_q == ISSUE) && we_q && !reset;
      bus.mem_addr  = reset ? 32'h0 : addr_q;
      bus.mem_wdata = reset ? 32'h0 : wdata_q;
      bus.if_ready  = in_done && gnt_if_q && !flushed_q && !bus.if_flush;
      bus.if_rdata  = reset ? 32'h0 : if_rdata_q;
      bus.dm_ready  = in_done && !gnt_if_q;
      bus.dm_err    = in_done && !gnt_if_q && err_q;
      bus.dm_rdata  = reset ? 32'h0 : dm_rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
// Latency: n/a.
// Backpressure: requesters hold requests until ready (fetch may withdraw on flush).
module tb_mem_port_arbiter;
   localparam int MEM_LAT       = 1;
   localparam int MAX_DM_STREAK = 3;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_DM_STREAK(MAX_DM_STREAK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = -1;

   // stimulus staged for the next cycle
   bit          s_reset, s_if_req, s_if_flush, s_dm_req, s_dm_we;
   logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;

   // memory environment
   logic [31:0] mem      [logic [31:0]];
   logic [31:0] rd_sched [int];

   // reference model: one transaction record plus starvation counter
   int          t_kind = 0;      // 0 none, 1 fetch, 2 data
   bit          t_we, t_err, t_flushed;
   logic [31:0] t_addr, t_wdata, t_rdata;
   int          t_issue, t_done;
   int          streak = 0;
   logic [31:0] exp_dm_rdata = 32'h0;

   // directed-run trace
   bit          r_busy[32], r_en[32], r_we[32], r_ifr[32], r_dmr[32], r_err[32];
   logic [31:0] r_addr[32], r_ifd[32];
   int          seq_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   task automatic model_cycle();
      bit exp_busy, exp_en, exp_ifr, exp_dmr, exp_err, end_txn;
      bit f_ok, take_f, take_d;
      if (reset) begin
         check_eq("rst_busy", busy, 0);
         check_eq("rst_mem_en", bus.mem_en, 0);
         check_eq("rst_mem_we", bus.mem_we, 0);
         check_eq("rst_mem_addr", bus.mem_addr, 0);
         check_eq("rst_mem_wdata", bus.mem_wdata, 0);
         check_eq("rst_if_ready", bus.if_ready, 0);
         check_eq("rst_if_rdata", bus.if_rdata, 0);
         check_eq("rst_dm_ready", bus.dm_ready, 0);
         check_eq("rst_dm_rdata", bus.dm_rdata, 0);
         check_eq("rst_dm_err", bus.dm_err, 0);
         t_kind = 0;
         streak = 0;
         exp_dm_rdata = 32'h0;
         return;
      end
      exp_busy = (t_kind != 0);
      exp_en = 0; exp_ifr = 0; exp_dmr = 0; exp_err = 0; end_txn = 0;
      if (t_kind != 0) begin
         if (t_kind == 1 && bus.if_flush) t_flushed = 1;
         if (cyc == t_issue) begin
            exp_en = 1;
            check_eq("mem_we", bus.mem_we, t_we);
            check_eq("mem_addr", bus.mem_addr, t_addr);
            if (t_we) check_eq("mem_wdata", bus.mem_wdata, t_wdata);
            else t_rdata = mem_rd(t_addr);
         end
         if (cyc == t_done) begin
            exp_ifr = (t_kind == 1) && !t_flushed;
            exp_dmr = (t_kind == 2);
            exp_err = (t_kind == 2) && t_err;
            if (t_kind == 2 && !t_we && !t_err) exp_dm_rdata = t_rdata;
            if (exp_ifr) check_eq("if_rdata", bus.if_rdata, t_rdata);
            end_txn = 1;
         end
      end else begin
         f_ok   = bus.if_req && !bus.if_flush;
         take_f = f_ok && (!bus.dm_req || streak == MAX_DM_STREAK);
         take_d = !take_f && bus.dm_req;
         if (!bus.if_req || take_f) streak = 0;
         else if (take_d && streak < MAX_DM_STREAK) streak = streak + 1;
         if (take_f) begin
            t_kind = 1; t_we = 0; t_err = 0; t_flushed = 0;
            t_addr = bus.if_addr & ~32'h3; t_wdata = 0;
            t_issue = cyc + 1; t_done = cyc + 2 + MEM_LAT;
         end else if (take_d) begin
            t_kind = 2; t_we = bus.dm_we; t_flushed = 0;
            t_err = (bus.dm_addr[1:0] != 2'b00);
            t_addr = bus.dm_addr & ~32'h3; t_wdata = bus.dm_wdata;
            if (t_err) begin t_issue = -1; t_done = cyc + 1; end
            else begin
               t_issue = cyc + 1;
               t_done  = t_we ? cyc + 2 : cyc + 2 + MEM_LAT;
            end
         end
      end
      check_eq("busy", busy, exp_busy);
      check_eq("mem_en", bus.mem_en, exp_en);
      check_eq("if_ready", bus.if_ready, exp_ifr);
      check_eq("dm_ready", bus.dm_ready, exp_dmr);
      check_eq("dm_err", bus.dm_err, exp_err);
      check_eq("dm_rdata", bus.dm_rdata, exp_dm_rdata);
      if (end_txn) t_kind = 0;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      reset        = s_reset;
      bus.if_req   = s_if_req;
      bus.if_addr  = s_if_addr;
      bus.if_flush = s_if_flush;
      bus.dm_req   = s_dm_req;
      bus.dm_we    = s_dm_we;
      bus.dm_addr  = s_dm_addr;
      bus.dm_wdata = s_dm_wdata;
      if (rd_sched.exists(cyc)) begin
         bus.mem_rdata = rd_sched[cyc];
         rd_sched.delete(cyc);
      end else begin
         bus.mem_rdata = $urandom();
      end
      @(negedge clk);
      model_cycle();
      if (bus.mem_en === 1'b1) begin
         if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
         else rd_sched[cyc + MEM_LAT] = mem_rd(bus.mem_addr);
      end
   endtask

   task automatic quiet(input int n);
      s_if_req = 0; s_dm_req = 0; s_if_flush = 0; s_reset = 0;
      repeat (n) step();
   endtask

   task automatic directed(input int n, input int flush_at, input int reset_at);
      for (int i = 0; i < n; i++) begin
         s_if_flush = (i == flush_at);
         s_reset    = (i == reset_at);
         if (i == reset_at) begin s_if_req = 0; s_dm_req = 0; end
         step();
         r_busy[i] = busy;           r_en[i]  = bus.mem_en;
         r_we[i]   = bus.mem_we;     r_addr[i] = bus.mem_addr;
         r_ifr[i]  = bus.if_ready;   r_ifd[i]  = bus.if_rdata;
         r_dmr[i]  = bus.dm_ready;   r_err[i]  = bus.dm_err;
         if (s_if_flush || bus.if_ready) s_if_req = 0;
         if (bus.dm_ready) s_dm_req = 0;
      end
      s_if_flush = 0;
      s_reset    = 0;
   endtask

   function automatic int count_bits(input bit v[32], input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic requesters();
      bit was_flush;
      was_flush  = s_if_flush;
      s_if_flush = 0;
      if (s_if_req && (was_flush || bus.if_ready)) s_if_req = 0;
      if (s_dm_req && bus.dm_ready) s_dm_req = 0;
      s_reset = ($urandom_range(0, 249) == 0);
      if (s_reset) begin
         s_if_req = 0;
         s_dm_req = 0;
         return;
      end
      if (!s_if_req) begin
         if ($urandom_range(0, 2) == 0) begin
            s_if_req  = 1;
            s_if_addr = 32'($urandom_range(0, 255)) << 2;
         end
      end else if ($urandom_range(0, 9) == 0) begin
         s_if_flush = 1;
      end
      if (!s_dm_req && $urandom_range(0, 1) == 0) begin
         s_dm_req   = 1;
         s_dm_we    = ($urandom_range(0, 1) == 1);
         s_dm_addr  = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 5) == 0) s_dm_addr[1:0] = 2'($urandom_range(1, 3));
         s_dm_wdata = $urandom();
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
      bus.mem_rdata = 0;
      s_reset = 1; s_if_req = 0; s_if_flush = 0; s_dm_req = 0; s_dm_we = 0;
      s_if_addr = 0; s_dm_addr = 0; s_dm_wdata = 0;
      mem[32'h40] = 32'h00500093;

      repeat (3) step();
      quiet(3);

      // fetch from 0x40
      s_if_req = 1; s_if_addr = 32'h40;
      directed(6, -1, -1);
      check_eq("fetch_en_c1", r_en[1], 1);
      check_eq("fetch_en_count", count_bits(r_en, 6), 1);
      check_eq("fetch_ready_c3", r_ifr[3], 1);
      check_eq("fetch_rdata_c3", r_ifd[3], 32'h00500093);
      quiet(2);

      // simultaneous fetch and load: data first
      s_if_req = 1; s_if_addr = 32'h80;
      s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h100;
      directed(10, -1, -1);
      check_eq("both_dm_ready_c3", r_dmr[3], 1);
      check_eq("both_if_ready_c7", r_ifr[7], 1);
      check_eq("both_if_ready_count", count_bits(r_ifr, 10), 1);
      quiet(2);

      // aligned store
      s_dm_req = 1; s_dm_we = 1; s_dm_addr = 32'h0C; s_dm_wdata = 32'hDEADBEEF;
      directed(4, -1, -1);
      check_eq("sw_en_count", count_bits(r_en, 4), 1);
      check_eq("sw_en_c1", r_en[1], 1);
      check_eq("sw_we_c1", r_we[1], 1);
      check_eq("sw_addr_c1", r_addr[1], 32'h0C);
      check_eq("sw_ready_c2", r_dmr[2], 1);

      // misaligned load
      s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h102;
      directed(3, -1, -1);
      check_eq("mis_en_count", count_bits(r_en, 3), 0);
      check_eq("mis_ready_c1", r_dmr[1], 1);
      check_eq("mis_err_c1", r_err[1], 1);
      quiet(2);

      // flush in WAIT of a fetch
      s_if_req = 1; s_if_addr = 32'h44;
      directed(6, 2, -1);
      check_eq("flush_no_ready", count_bits(r_ifr, 6), 0);
      check_eq("flush_busy_c3", r_busy[3], 1);
      check_eq("flush_idle_c4", r_busy[4], 0);
      quiet(2);

      // reset in WAIT of a fetch
      s_if_req = 1; s_if_addr = 32'h48;
      directed(5, -1, 2);
      check_eq("rstw_busy_c1", r_busy[1], 1);
      check_eq("rstw_busy_c3", r_busy[3], 0);
      check_eq("rstw_no_ready", count_bits(r_ifr, 5), 0);
      quiet(3);

      // data streak with fetch waiting
      s_if_req = 1; s_if_addr = 32'h50;
      s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h20;
      for (int i = 0; i < 80 && seq_q.size() < 8; i++) begin
         step();
         if (bus.dm_ready) begin seq_q.push_back(0); s_dm_addr += 4; end
         if (bus.if_ready) begin seq_q.push_back(1); s_if_addr += 4; end
      end
      check_eq("streak_grants", seq_q.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < seq_q.size()) check_eq("streak_order", seq_q[k], (k % 4 == 3) ? 1 : 0);
      end
      quiet(3);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step();
         requesters();
      end
      quiet(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles after the issue cycle; legal range 1..7.
REQ-002 Parameter MAX_DM_STREAK, default 3, number of consecutive data grants allowed while fetch waits.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch request; held with if_addr until if_ready or if_flush.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_flush  in  1  taken branch/jump; cancels the outstanding fetch.
REQ-008 if_ready  out  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  out  32  fetched instruction.
REQ-010 dm_req  in  1  data request (MemRead or MemWrite); held with dm_* until dm_ready.
REQ-011 dm_we  in  1  1 = store (sw), 0 = load (lw).
REQ-012 dm_addr  in  32  data byte address.
REQ-013 dm_wdata  in  32  store data.
REQ-014 dm_ready  out  1  one-cycle completion pulse; dm_rdata valid for loads.
REQ-015 dm_rdata  out  32  load data.
REQ-016 dm_err  out  1  pulses with dm_ready for a misaligned access.
REQ-017 mem_en, mem_we  out  1 each  single-port memory strobe and write enable.
REQ-018 mem_addr, mem_wdata  out  32 each  memory word address ([1:0] = 0) and write data.
REQ-019 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE: with no request asserted, stay in IDLE; with any request, latch the winner, address, we and wdata, then go to ISSUE.
REQ-023 Arbitration: data wins over fetch, except fetch wins when streak_cnt == MAX_DM_STREAK and if_req is high.
REQ-024 streak_cnt SHALL increment on a data grant while if_req is high, and SHALL clear on a fetch grant or whenever if_req is low in IDLE.
REQ-025 ISSUE: assert mem_en for exactly one cycle with the latched address, we and wdata; mem_en SHALL be 0 in all other states.
REQ-026 After ISSUE, a store goes to DONE, and a load or fetch goes to WAIT.
REQ-027 WAIT: stay MEM_LAT cycles, sample mem_rdata into the read register at the end of the last WAIT cycle, then go to DONE.
REQ-028 DONE: pulse the granted requester's ready for one cycle, then return to IDLE; rdata outputs SHALL hold until the next capture.
REQ-029 Latency from the request sampled in IDLE cycle 0: store ready in cycle 2; load or fetch ready in cycle 2+MEM_LAT.
REQ-030 A data access with dm_addr[1:0] != 0 SHALL skip ISSUE and WAIT (no mem_en), go to DONE, and pulse dm_ready with dm_err=1.
REQ-031 if_flush during ISSUE, WAIT or DONE of a fetch SHALL let the memory access finish but suppress if_ready.
REQ-032 if_flush in IDLE SHALL block fetch from arbitration in that cycle; a data request in that cycle SHALL still be granted.
REQ-033 A request still high in the DONE cycle SHALL be ignored; it is re-arbitrated as a new request in the following IDLE cycle.
REQ-034 Requests asserted outside IDLE SHALL wait, with no loss, until the next IDLE.

Reset
REQ-035 While reset=1 at the clock edge: state = IDLE, streak_cnt = 0, and grant/latched registers = 0.
REQ-036 While reset=1, all outputs SHALL be 0, including rdata registers and mem_addr.
REQ-037 Reset mid-transaction SHALL abort it with no ready pulse; mem_en SHALL be 0 from the first reset cycle.

Verification
REQ-038 MEM_LAT=1; if_req with if_addr=0x40 and mem_rdata=0x00500093 -> mem_en in cycle 1, if_ready and if_rdata=0x00500093 in cycle 3.
REQ-039 if_req and dm_req (lw, 0x100) in the same cycle -> data granted first (dm_ready cycle 3), then fetch (if_ready cycle 7).
REQ-040 dm_req held continuously with if_req high, MAX_DM_STREAK=3 -> three data grants, then a fetch grant, then the streak restarts.
REQ-041 sw to 0x0C with wdata 0xDEADBEEF -> one mem_en cycle with mem_we=1, mem_addr=0x0C, then dm_ready in cycle 2; lw to 0x102 -> no mem_en, dm_ready=1 and dm_err=1 in cycle 1.
REQ-042 if_flush in the WAIT cycle of a fetch -> no if_ready pulse, FSM back in IDLE at cycle 4; reset in WAIT -> IDLE next cycle with all outputs 0.
